rollback_arbiter: RTL
=====================

Name: rollback_arbiter

Overview:
- Receives branch/exception rollback requests from the integer execute stage (ix_*) and the data-cache stage (dd_*).
- Resolves per-thread ordering and broadcasts one registered rollback per cycle (wb_rollback_*) that squashes all pipeline stages and redirects instruction fetch.
- Buffers requests that lose arbitration in per-thread pending slots until broadcast.

Parameters:
NUM_THREADS, 4, hardware threads per core; thread index width TIDX_W = $clog2(NUM_THREADS), minimum 1.
PC_WIDTH, 32, program counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ix_rollback_en  in  1  integer stage rollback request
ix_thread_idx  in  TIDX_W  requesting thread
ix_rollback_pc  in  PC_WIDTH  redirect target
ix_subcycle  in  4  subcycle to resume
dd_rollback_en  in  1  dcache stage rollback request (miss/fault replay)
dd_thread_idx  in  TIDX_W  requesting thread
dd_rollback_pc  in  PC_WIDTH  redirect target
dd_subcycle  in  4  subcycle to resume
wb_rollback_en  out  1  broadcast rollback, registered
wb_rollback_thread_idx  out  TIDX_W  thread being squashed
wb_rollback_pc  out  PC_WIDTH  new fetch PC
wb_rollback_subcycle  out  4  resume subcycle
wb_rollback_pending  out  NUM_THREADS  bit t set while thread t has a buffered, unbroadcast rollback (thread select must not issue it)

Behaviour:
- Reset (async, clk domain): wb_rollback_en=0, wb_rollback_thread_idx=0, wb_rollback_pc=0, wb_rollback_subcycle=0, all pending slots invalid, wb_rollback_pending=0, round-robin pointer=0.
- Per-thread pending slot fields: valid, pc, subcycle, src (IX or DD).
- Candidates in a cycle: valid pending slots, plus incoming requests after filtering.
- Filtering, in order:
  - An incoming request is dropped when its thread equals the thread of the registered wb_rollback_en output of the current cycle; that output has already squashed it.
  - dd and ix requests for the same thread in the same cycle: keep dd (older instruction), drop ix.
  - Incoming dd for a thread with a pending ix-sourced slot: replace that slot.
  - Any other incoming request for a thread with a valid slot: drop it (younger instruction).
- Selection, one winner per cycle:
  - Valid pending slots take priority, chosen round-robin starting from the pointer.
  - With no pending slot, a filtered dd request wins over a filtered ix request.
  - Winner is registered onto wb_rollback_* next edge: 1-cycle latency from request to wb_rollback_en with no contention.
- Losers are written into their thread's slot; the winner's slot is cleared the same edge.
- Round-robin pointer advances to winner_thread+1, modulo NUM_THREADS, only when a pending slot wins.
- Simultaneous clear and set of the same slot: set wins only for a DD replacement of a different thread; the same thread cannot be both winner and loser.
- wb_rollback_pending is combinational from slot valids.
- No cycle with any candidate may leave wb_rollback_en low the next cycle.
- Reset mid-operation discards all slots.

Optional Feature:
- Macro ROLLBACK_ARB_PERF_EN.
- Defined: adds outputs perf_rollback_deferred (1-cycle pulse when any request is written to a slot) and perf_rollback_dropped (pulse when any request is filtered out).
- Also adds internal 32-bit saturating counter deferred_count, readable on output perf_deferred_count, reset to 0.
- Undefined: ports and counter absent; functional behaviour identical.

Test Plan:
- Single ix request, thread 2, pc 0x1000, subcycle 0 -> next cycle wb_rollback_en=1, thread 2, pc 0x1000; following cycle en=0.
- ix thread 1 pc 0x200 and dd thread 3 pc 0x300 same cycle -> cycle+1 broadcasts thread 3/0x300, pending[1]=1; cycle+2 broadcasts thread 1/0x200, pending=0.
- ix and dd both thread 0 (pc 0x40 vs 0x80) -> only 0x80 broadcast, single pulse, dropped pulse with PERF_EN.
- Thread 1 pending from ix (0x500), then dd thread 1 pc 0x600 while thread 2 wins -> later broadcast of thread 1 uses 0x600.
- Request for thread 0 in the cycle wb_rollback_en=1 for thread 0 -> dropped, no second broadcast.
- Fill slots for threads 0-3 in consecutive cycles, then assert reset mid-drain -> all outputs 0 immediately, no further broadcasts after release.

Source files
------------

// File: rtl/rollback_arbiter.sv
// Rollback arbiter: merges ix/dd rollback requests, buffers losers per thread, broadcasts one registered rollback per cycle.
// Optional perf outputs and deferred counter enabled by defining ROLLBACK_ARB_PERF_EN.
module rollback_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  localparam int TIDX_W     = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ix_rollback_en,
  input  logic [TIDX_W-1:0]      ix_thread_idx,
  input  logic [PC_WIDTH-1:0]    ix_rollback_pc,
  input  logic [3:0]             ix_subcycle,
  input  logic                   dd_rollback_en,
  input  logic [TIDX_W-1:0]      dd_thread_idx,
  input  logic [PC_WIDTH-1:0]    dd_rollback_pc,
  input  logic [3:0]             dd_subcycle,
  output logic                   wb_rollback_en,
  output logic [TIDX_W-1:0]      wb_rollback_thread_idx,
  output logic [PC_WIDTH-1:0]    wb_rollback_pc,
  output logic [3:0]             wb_rollback_subcycle,
  output logic [NUM_THREADS-1:0] wb_rollback_pending
`ifdef ROLLBACK_ARB_PERF_EN
  ,
  output logic                   perf_rollback_deferred,
  output logic                   perf_rollback_dropped,
  output logic [31:0]            perf_deferred_count
`endif
);

  typedef enum logic {SRC_IX, SRC_DD} src_t;

  logic [NUM_THREADS-1:0] slot_valid, nxt_valid;
  logic [PC_WIDTH-1:0]    slot_pc  [NUM_THREADS];
  logic [PC_WIDTH-1:0]    nxt_pc   [NUM_THREADS];
  logic [3:0]             slot_sub [NUM_THREADS];
  logic [3:0]             nxt_sub  [NUM_THREADS];
  src_t                   slot_src [NUM_THREADS];
  src_t                   nxt_src  [NUM_THREADS];
  logic [TIDX_W-1:0]      rr_ptr, nxt_ptr;

  logic ix_live, dd_live, dd_replace, dd_new, ix_new;
  logic slot_win, dd_win, ix_win, win_en;
  logic [TIDX_W-1:0]   slot_win_t, win_t;
  logic [PC_WIDTH-1:0] win_pc;
  logic [3:0]          win_sub;
  int unsigned         rr_idx;

  always_comb begin
    ix_live = ix_rollback_en && !(wb_rollback_en && ix_thread_idx == wb_rollback_thread_idx);
    dd_live = dd_rollback_en && !(wb_rollback_en && dd_thread_idx == wb_rollback_thread_idx);
    if (dd_live && ix_live && ix_thread_idx == dd_thread_idx)
      ix_live = 1'b0;
    dd_replace = dd_live && slot_valid[dd_thread_idx] && (slot_src[dd_thread_idx] == SRC_IX);
    dd_new     = dd_live && !slot_valid[dd_thread_idx];
    ix_new     = ix_live && !slot_valid[ix_thread_idx];
  end

  always_comb begin
    nxt_valid = slot_valid;
    nxt_pc    = slot_pc;
    nxt_sub   = slot_sub;
    nxt_src   = slot_src;
    nxt_ptr   = rr_ptr;
    // The dd replacement is applied before selection, so a slot that wins
    // this same cycle broadcasts the older (dd) instruction's target.
    if (dd_replace) begin
      nxt_pc[dd_thread_idx]  = dd_rollback_pc;
      nxt_sub[dd_thread_idx] = dd_subcycle;
      nxt_src[dd_thread_idx] = SRC_DD;
    end

    slot_win   = 1'b0;
    slot_win_t = '0;
    rr_idx     = 0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      rr_idx = 32'(rr_ptr) + i;
      if (rr_idx >= 32'(NUM_THREADS))
        rr_idx = rr_idx - 32'(NUM_THREADS);
      if (!slot_win && slot_valid[TIDX_W'(rr_idx)]) begin
        slot_win   = 1'b1;
        slot_win_t = TIDX_W'(rr_idx);
      end
    end

    win_en  = 1'b0;
    win_t   = '0;
    win_pc  = '0;
    win_sub = '0;
    dd_win  = 1'b0;
    ix_win  = 1'b0;
    if (slot_win) begin
      win_en                = 1'b1;
      win_t                 = slot_win_t;
      win_pc                = nxt_pc[slot_win_t];
      win_sub               = nxt_sub[slot_win_t];
      nxt_valid[slot_win_t] = 1'b0;
      nxt_ptr = (slot_win_t == TIDX_W'(NUM_THREADS - 1)) ? '0 : slot_win_t + 1'b1;
    end else if (dd_new) begin
      win_en  = 1'b1;
      dd_win  = 1'b1;
      win_t   = dd_thread_idx;
      win_pc  = dd_rollback_pc;
      win_sub = dd_subcycle;
    end else if (ix_new) begin
      win_en  = 1'b1;
      ix_win  = 1'b1;
      win_t   = ix_thread_idx;
      win_pc  = ix_rollback_pc;
      win_sub = ix_subcycle;
    end

    if (dd_new && !dd_win) begin
      nxt_valid[dd_thread_idx] = 1'b1;
      nxt_pc[dd_thread_idx]    = dd_rollback_pc;
      nxt_sub[dd_thread_idx]   = dd_subcycle;
      nxt_src[dd_thread_idx]   = SRC_DD;
    end
    if (ix_new && !ix_win) begin
      nxt_valid[ix_thread_idx] = 1'b1;
      nxt_pc[ix_thread_idx]    = ix_rollback_pc;
      nxt_sub[ix_thread_idx]   = ix_subcycle;
      nxt_src[ix_thread_idx]   = SRC_IX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid             <= '0;
      rr_ptr                 <= '0;
      wb_rollback_en         <= 1'b0;
      wb_rollback_thread_idx <= '0;
      wb_rollback_pc         <= '0;
      wb_rollback_subcycle   <= '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        slot_pc[i]  <= '0;
        slot_sub[i] <= '0;
        slot_src[i] <= SRC_IX;
      end
    end else begin
      slot_valid     <= nxt_valid;
      slot_pc        <= nxt_pc;
      slot_sub       <= nxt_sub;
      slot_src       <= nxt_src;
      rr_ptr         <= nxt_ptr;
      wb_rollback_en <= win_en;
      if (win_en) begin
        wb_rollback_thread_idx <= win_t;
        wb_rollback_pc         <= win_pc;
        wb_rollback_subcycle   <= win_sub;
      end
    end
  end

  assign wb_rollback_pending = slot_valid;

`ifdef ROLLBACK_ARB_PERF_EN
  logic [1:0]  n_deferred;
  logic        any_dropped;
  logic [31:0] deferred_count;
  logic [32:0] deferred_sum;

  always_comb begin
    n_deferred = {1'b0, dd_new && !dd_win} + {1'b0, ix_new && !ix_win}
               + {1'b0, dd_replace && !(slot_win && slot_win_t == dd_thread_idx)};
    any_dropped = (ix_rollback_en && !ix_new) || (dd_rollback_en && !dd_new && !dd_replace);
    deferred_sum = {1'b0, deferred_count} + 33'(n_deferred);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rollback_deferred <= 1'b0;
      perf_rollback_dropped  <= 1'b0;
      deferred_count         <= '0;
    end else begin
      perf_rollback_deferred <= (n_deferred != 2'd0);
      perf_rollback_dropped  <= any_dropped;
      deferred_count         <= deferred_sum[32] ? '1 : deferred_sum[31:0];
    end
  end

  assign perf_deferred_count = deferred_count;
`endif

endmodule
